instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Fetch stage directly upstream of instruction_decoder. It holds the PC and issues 16-bit instruction reads over a simple request/acknowledge memory handshake. Each returned word is registered onto Instr, and a one-cycle E pulse is raised to drive the decoder's Instr/E inputs. It also handles stall back-pressure from downstream, branch/PC loads from execute, and odd-address faults.

Parameters:
ADDR_W, 16, width of PC and memory address.
RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
Clock  input  1  system clock; all state changes on posedge.
Reset_n  input  1  asynchronous, active-low reset.
Run  input  1  fetch enable; 0 = finish any in-flight fetch, then idle.
Stall  input  1  downstream busy; 1 = no E pulse may be issued.
BrLoad  input  1  PC load request from execute (branch, BL, PC write).
BrTarget  input  ADDR_W  new PC, used when BrLoad=1.
MemAddr  output  ADDR_W  fetch address; stable while MemRd=1.
MemRd  output  1  read request.
MemAck  input  1  read complete; MemData valid in the same cycle.
MemData  input  16  instruction word.
Instr  output  16  instruction to decoder.
E  output  1  one-cycle decode enable; Instr is valid whenever E=1.
InstrPC  output  ADDR_W  address the current Instr was fetched from.
PC  output  ADDR_W  next fetch address.
FLT  output  1  sticky odd-address fault.

Behaviour:
- Reset (async, Reset_n=0):
  - PC=RESET_PC; MemAddr=0, MemRd=0, Instr=0, E=0, InstrPC=0, FLT=0.
  - State=IDLE.
- State machine: IDLE, REQ, HOLD, FAULT.
- IDLE: if Run=1, go to REQ with MemRd=1 and MemAddr=PC.
- REQ:
  - MemRd and MemAddr stay constant until MemAck=1 is sampled.
  - On ack: Instr<=MemData, InstrPC<=MemAddr, PC<=PC+2 (modulo 2^ADDR_W, so 16'hFFFE wraps to 0).
  - If Stall=0 at the ack edge: E<=1 for the next cycle.
    - If Run=1, stay in REQ with MemAddr=new PC and MemRd kept at 1. With zero-wait memory this gives back-to-back fetch, one instruction per cycle.
    - If Run=0, go to IDLE with MemRd<=0.
  - If Stall=1 at the ack edge: go to HOLD with MemRd<=0.
- HOLD:
  - Instr is held and E=0.
  - When Stall is sampled 0, pulse E for one cycle, then go to REQ (Run=1) or IDLE (Run=0).
- E is never high for two consecutive cycles for the same Instr.
- Instr changes only on a capture edge.
- BrLoad has the highest priority in IDLE, REQ and HOLD:
  - PC<=BrTarget.
  - Any outstanding request is abandoned: MemRd<=0 for exactly one cycle, and a MemAck in the same cycle as BrLoad is discarded.
  - A held (un-issued) instruction is discarded with no E.
  - Next state is REQ if Run=1, otherwise IDLE.
  - If BrTarget[0]=1: FLT<=1 and go to FAULT; PC is still loaded.
- Stall=1 at the same edge as BrLoad: BrLoad wins.
- FAULT: MemRd=0, E=0, FLT=1; exits only via Reset_n.
- Reset mid-request drops MemRd immediately (async). Memory must tolerate an abandoned request.
- MemAck while MemRd=0 is ignored.

Optional Feature:
Macro FETCH_BKPT_EN.
- Defined:
  - Adds ports BkptAddr (input ADDR_W), BkptEn (input 1), BkptHit (output 1, reset 0).
  - Before any request is issued (entering REQ or issuing the next address), if BkptEn=1 and PC==BkptAddr: no MemRd, BkptHit<=1, state holds in a BKPT state.
  - BKPT is left when BkptEn=0 (fetch resumes at PC, BkptHit<=0) or on BrLoad (normal BrLoad rules, BkptHit<=0).
- Undefined: ports and state absent; behaviour exactly as above.

Test Plan:
- Reset with RESET_PC=16'h0100, Run=1, zero-wait memory returning 16'h4012 at 0x0100 → MemAddr=0x0100; next cycle Instr=16'h4012, E=1, InstrPC=0x0100, PC=0x0102.
- 3-cycle ack latency at 0x0200 → MemAddr held at 0x0200 for all 3 cycles; exactly one E pulse.
- Stall=1 when the word at 0x0104 is acked, released 4 cycles later → E=0 during the stall, a single E pulse with Instr unchanged, then fetch of 0x0106.
- BrLoad=1 with BrTarget=0x0400 in the same cycle as MemAck for 0x0108 → no E for that word; next MemAddr=0x0400.
- BrLoad with BrTarget=0x0301 → FLT=1, MemRd=0, E stays 0 until Reset_n; PC=16'hFFFE fetch → PC wraps to 0x0000.
- (FETCH_BKPT_EN) BkptEn=1, BkptAddr=0x0110, run from 0x010C → fetches 0x010C and 0x010E only, BkptHit=1; drop BkptEn → fetch of 0x0110 resumes.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, req/ack fetch, stall hold, branch load, fault.
// Optional FETCH_BKPT_EN: PC breakpoint that parks fetch in BKPT.
module instruction_fetch #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Run,
  input  logic              Stall,
  input  logic              BrLoad,
  input  logic [ADDR_W-1:0] BrTarget,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRd,
  input  logic              MemAck,
  input  logic [15:0]       MemData,
  output logic [15:0]       Instr,
  output logic              E,
  output logic [ADDR_W-1:0] InstrPC,
  output logic [ADDR_W-1:0] PC,
`ifdef FETCH_BKPT_EN
  input  logic [ADDR_W-1:0] BkptAddr,
  input  logic              BkptEn,
  output logic              BkptHit,
`endif
  output logic              FLT
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    HOLD,
    FAULT
`ifdef FETCH_BKPT_EN
    , BKPT
`endif
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] pc_q, pc_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [ADDR_W-1:0] ipc_q, ipc_n;
  logic [ADDR_W-1:0] pc_inc, iaddr;
  logic [15:0]       instr_q, instr_n;
  logic              rd_q, rd_n;
  logic              e_q, e_n;
  logic              flt_q, flt_n;
  logic              issue, br;
`ifdef FETCH_BKPT_EN
  logic              hit_q, hit_n;
`endif

  assign pc_inc = pc_q + ADDR_W'(2);

  // State and datapath registers
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      e_q     <= 1'b0;
      flt_q   <= 1'b0;
`ifdef FETCH_BKPT_EN
      hit_q   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      pc_q    <= pc_n;
      addr_q  <= addr_n;
      rd_q    <= rd_n;
      instr_q <= instr_n;
      ipc_q   <= ipc_n;
      e_q     <= e_n;
      flt_q   <= flt_n;
`ifdef FETCH_BKPT_EN
      hit_q   <= hit_n;
`endif
    end
  end

  // Next state: per-state decision, then shared branch and issue paths
  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    addr_n  = addr_q;
    rd_n    = rd_q;
    instr_n = instr_q;
    ipc_n   = ipc_q;
    e_n     = 1'b0;
    flt_n   = flt_q;
    issue   = 1'b0;
    br      = 1'b0;
    iaddr   = pc_q;
`ifdef FETCH_BKPT_EN
    hit_n   = hit_q;
`endif
    unique case (state)
      IDLE: begin
        if (BrLoad) br = 1'b1;
        else if (Run) issue = 1'b1;
      end
      REQ: begin
        if (BrLoad) begin
          br = 1'b1;
        end else if (!rd_q) begin
          if (Run) issue = 1'b1;
          else state_n = IDLE;
        end else if (MemAck) begin
          instr_n = MemData;
          ipc_n   = addr_q;
          pc_n    = pc_inc;
          if (Stall) begin
            state_n = HOLD;
            rd_n    = 1'b0;
          end else begin
            e_n = 1'b1;
            if (Run) begin
              issue = 1'b1;
              iaddr = pc_inc;
            end else begin
              state_n = IDLE;
              rd_n    = 1'b0;
            end
          end
        end
      end
      HOLD: begin
        if (BrLoad) begin
          br = 1'b1;
        end else if (!Stall) begin
          e_n = 1'b1;
          if (Run) issue = 1'b1;
          else state_n = IDLE;
        end
      end
      FAULT: begin
        rd_n = 1'b0;
      end
`ifdef FETCH_BKPT_EN
      BKPT: begin
        if (BrLoad) begin
          br = 1'b1;
        end else if (!BkptEn) begin
          hit_n = 1'b0;
          if (Run) issue = 1'b1;
          else state_n = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase

    if (br) begin
      pc_n = BrTarget;
      rd_n = 1'b0;
      e_n  = 1'b0;
`ifdef FETCH_BKPT_EN
      hit_n = 1'b0;
`endif
      if (BrTarget[0]) begin
        flt_n   = 1'b1;
        state_n = FAULT;
      end else begin
        state_n = Run ? REQ : IDLE;
      end
    end

    if (issue) begin
`ifdef FETCH_BKPT_EN
      if (BkptEn && iaddr == BkptAddr) begin
        state_n = BKPT;
        rd_n    = 1'b0;
        hit_n   = 1'b1;
      end else
`endif
      begin
        state_n = REQ;
        rd_n    = 1'b1;
        addr_n  = iaddr;
      end
    end
  end

  assign MemAddr = addr_q;
  assign MemRd   = rd_q;
  assign Instr   = instr_q;
  assign E       = e_q;
  assign InstrPC = ipc_q;
  assign PC      = pc_q;
  assign FLT     = flt_q;
`ifdef FETCH_BKPT_EN
  assign BkptHit = hit_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed plan scenarios plus randomized run
// checked against a program-order fetch scoreboard.
module tb_instruction_fetch;

  logic        Clock = 1'b0;
  logic        Reset_n, Run, Stall, BrLoad, MemAck;
  logic [15:0] BrTarget, MemData;
  logic [15:0] MemAddr, Instr, InstrPC, PC;
  logic        MemRd, E, FLT;
`ifdef FETCH_BKPT_EN
  logic [15:0] BkptAddr;
  logic        BkptEn, BkptHit;
`endif

  int checks   = 0;
  int failures = 0;
  int lat      = 1;
  int wcnt     = 0;
  bit rand_lat = 1'b0;
  bit junk     = 1'b0;

  instruction_fetch #(.ADDR_W(16), .RESET_PC(16'h0100)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Run(Run), .Stall(Stall),
    .BrLoad(BrLoad), .BrTarget(BrTarget),
    .MemAddr(MemAddr), .MemRd(MemRd), .MemAck(MemAck),
    .MemData(MemData), .Instr(Instr), .E(E), .InstrPC(InstrPC),
    .PC(PC),
`ifdef FETCH_BKPT_EN
    .BkptAddr(BkptAddr), .BkptEn(BkptEn), .BkptHit(BkptHit),
`endif
    .FLT(FLT)
  );

  always #5 Clock = ~Clock;

  function automatic logic [15:0] memword(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h4013;
  endfunction

  // memory: ack after lat cycles of MemRd; junk acks while idle
  task automatic respond();
    if (MemRd) begin
      if (wcnt >= lat - 1) begin
        MemAck = 1'b1;
        MemData = memword(MemAddr);
        wcnt = 0;
        if (rand_lat) lat = $urandom_range(1, 3);
      end else begin
        MemAck = 1'b0;
        MemData = 16'($urandom);
        wcnt++;
      end
    end else begin
      wcnt = 0;
      MemAck = junk ? 1'($urandom % 2) : 1'b0;
      MemData = 16'($urandom);
      if (rand_lat) lat = $urandom_range(1, 3);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
    respond();
  endtask

  task automatic drive_idle();
    Run = 1'b0; Stall = 1'b0; BrLoad = 1'b0; BrTarget = '0;
    MemAck = 1'b0; MemData = '0; wcnt = 0;
`ifdef FETCH_BKPT_EN
    BkptEn = 1'b0; BkptAddr = '0;
`endif
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset_n = 1'b0;
    drive_idle();
    @(negedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge Clock);
    Reset_n = 1'b0;
    drive_idle();
    #2;
    checks++; if (PC !== 16'h0100) begin failures++; $display("FAIL rst_pc act=%h req=%h", PC, 16'h0100); end
    checks++; if (MemAddr !== 16'h0000) begin failures++; $display("FAIL rst_addr act=%h req=0000", MemAddr); end
    checks++; if (MemRd !== 1'b0) begin failures++; $display("FAIL rst_rd act=%b req=0", MemRd); end
    checks++; if (Instr !== 16'h0000) begin failures++; $display("FAIL rst_instr act=%h req=0000", Instr); end
    checks++; if (E !== 1'b0) begin failures++; $display("FAIL rst_e act=%b req=0", E); end
    checks++; if (InstrPC !== 16'h0000) begin failures++; $display("FAIL rst_ipc act=%h req=0000", InstrPC); end
    checks++; if (FLT !== 1'b0) begin failures++; $display("FAIL rst_flt act=%b req=0", FLT); end
`ifdef FETCH_BKPT_EN
    checks++; if (BkptHit !== 1'b0) begin failures++; $display("FAIL rst_hit act=%b req=0", BkptHit); end
`endif
    @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  task automatic test_first_fetch();
    lat = 1;
    Run = 1'b1;
    cyc();
    checks++; if (MemRd !== 1'b1 || MemAddr !== 16'h0100) begin failures++; $display("FAIL ff_req act=%b/%h req=1/0100", MemRd, MemAddr); end
    cyc();
    checks++; if (Instr !== 16'h4012 || E !== 1'b1) begin failures++; $display("FAIL ff_instr act=%h/%b req=4012/1", Instr, E); end
    checks++; if (InstrPC !== 16'h0100 || PC !== 16'h0102) begin failures++; $display("FAIL ff_pc act=%h/%h req=0100/0102", InstrPC, PC); end
  endtask

  task automatic test_stall();
    cyc();
    checks++; if (E !== 1'b1 || InstrPC !== 16'h0102 || MemAddr !== 16'h0104) begin failures++; $display("FAIL st_pre act=%b/%h/%h req=1/0102/0104", E, InstrPC, MemAddr); end
    Stall = 1'b1;
    cyc();
    checks++; if (E !== 1'b0 || MemRd !== 1'b0) begin failures++; $display("FAIL st_cap act=%b/%b req=0/0", E, MemRd); end
    checks++; if (Instr !== memword(16'h0104) || PC !== 16'h0106) begin failures++; $display("FAIL st_word act=%h/%h req=%h/0106", Instr, PC, memword(16'h0104)); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (E !== 1'b0 || Instr !== memword(16'h0104)) begin failures++; $display("FAIL st_hold%0d act=%b/%h req=0/%h", i, E, Instr, memword(16'h0104)); end
    end
    Stall = 1'b0;
    cyc();
    checks++; if (E !== 1'b1 || Instr !== memword(16'h0104) || InstrPC !== 16'h0104) begin failures++; $display("FAIL st_rel act=%b/%h/%h req=1/%h/0104", E, Instr, InstrPC, memword(16'h0104)); end
    checks++; if (MemRd !== 1'b1 || MemAddr !== 16'h0106) begin failures++; $display("FAIL st_next act=%b/%h req=1/0106", MemRd, MemAddr); end
    cyc();
    checks++; if (E !== 1'b1 || InstrPC !== 16'h0106) begin failures++; $display("FAIL st_after act=%b/%h req=1/0106", E, InstrPC); end
  endtask

  task automatic test_branch_on_ack();
    checks++; if (MemAddr !== 16'h0108 || MemRd !== 1'b1) begin failures++; $display("FAIL br_pre act=%h/%b req=0108/1", MemAddr, MemRd); end
    BrLoad = 1'b1; BrTarget = 16'h0400;
    cyc();
    BrLoad = 1'b0;
    checks++; if (E !== 1'b0 || MemRd !== 1'b0 || PC !== 16'h0400) begin failures++; $display("FAIL br_edge act=%b/%b/%h req=0/0/0400", E, MemRd, PC); end
    checks++; if (Instr !== memword(16'h0106)) begin failures++; $display("FAIL br_instr act=%h req=%h", Instr, memword(16'h0106)); end
    cyc();
    checks++; if (MemRd !== 1'b1 || MemAddr !== 16'h0400 || E !== 1'b0) begin failures++; $display("FAIL br_issue act=%b/%h/%b req=1/0400/0", MemRd, MemAddr, E); end
    cyc();
    checks++; if (E !== 1'b1 || InstrPC !== 16'h0400) begin failures++; $display("FAIL br_fetch act=%b/%h req=1/0400", E, InstrPC); end
  endtask

  task automatic test_latency();
    int ne;
    BrLoad = 1'b1; BrTarget = 16'h0200;
    lat = 3;
    cyc();
    BrLoad = 1'b0;
    cyc();
    ne = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (MemRd !== 1'b1 || MemAddr !== 16'h0200) begin failures++; $display("FAIL lat_hold%0d act=%b/%h req=1/0200", i, MemRd, MemAddr); end
      if (E) ne++;
      cyc();
    end
    checks++; if (E !== 1'b1 || InstrPC !== 16'h0200 || Instr !== memword(16'h0200)) begin failures++; $display("FAIL lat_cap act=%b/%h/%h req=1/0200/%h", E, InstrPC, Instr, memword(16'h0200)); end
    ne += int'(E);
    cyc();
    ne += int'(E);
    checks++; if (ne !== 1) begin failures++; $display("FAIL lat_epulses act=%0d req=1", ne); end
  endtask

  task automatic test_wrap();
    lat = 1;
    BrLoad = 1'b1; BrTarget = 16'hFFFE;
    cyc();
    BrLoad = 1'b0;
    cyc();
    checks++; if (MemAddr !== 16'hFFFE || MemRd !== 1'b1) begin failures++; $display("FAIL wr_req act=%h/%b req=FFFE/1", MemAddr, MemRd); end
    cyc();
    checks++; if (E !== 1'b1 || InstrPC !== 16'hFFFE) begin failures++; $display("FAIL wr_cap act=%b/%h req=1/FFFE", E, InstrPC); end
    checks++; if (PC !== 16'h0000 || MemAddr !== 16'h0000) begin failures++; $display("FAIL wr_pc act=%h/%h req=0000/0000", PC, MemAddr); end
  endtask

  task automatic test_run_stop();
    Run = 1'b0;
    cyc();
    checks++; if (E !== 1'b1 || InstrPC !== 16'h0000 || MemRd !== 1'b0) begin failures++; $display("FAIL rs_last act=%b/%h/%b req=1/0000/0", E, InstrPC, MemRd); end
    cyc();
    cyc();
    checks++; if (E !== 1'b0 || MemRd !== 1'b0 || PC !== 16'h0002) begin failures++; $display("FAIL rs_idle act=%b/%b/%h req=0/0/0002", E, MemRd, PC); end
    Run = 1'b1;
    cyc();
    checks++; if (MemRd !== 1'b1 || MemAddr !== 16'h0002) begin failures++; $display("FAIL rs_resume act=%b/%h req=1/0002", MemRd, MemAddr); end
  endtask

  task automatic test_async_reset();
    #2;
    Reset_n = 1'b0;
    #1;
    checks++; if (MemRd !== 1'b0 || PC !== 16'h0100 || E !== 1'b0) begin failures++; $display("FAIL ar act=%b/%h/%b req=0/0100/0", MemRd, PC, E); end
    @(negedge Clock);
    drive_idle();
    Reset_n = 1'b1;
  endtask

  task automatic test_fault();
    Run = 1'b1;
    BrLoad = 1'b1; BrTarget = 16'h0301;
    cyc();
    BrLoad = 1'b0;
    checks++; if (FLT !== 1'b1 || MemRd !== 1'b0 || E !== 1'b0 || PC !== 16'h0301) begin failures++; $display("FAIL flt_set act=%b/%b/%b/%h req=1/0/0/0301", FLT, MemRd, E, PC); end
    junk = 1'b1;
    for (int i = 0; i < 6; i++) begin
      Stall = 1'($urandom % 2);
      BrLoad = (i == 2);
      BrTarget = 16'h0500;
      cyc();
      checks++; if (FLT !== 1'b1 || MemRd !== 1'b0 || E !== 1'b0) begin failures++; $display("FAIL flt_stay%0d act=%b/%b/%b req=1/0/0", i, FLT, MemRd, E); end
    end
    junk = 1'b0;
    do_reset();
    #1;
    checks++; if (FLT !== 1'b0) begin failures++; $display("FAIL flt_clr act=%b req=0", FLT); end
  endtask

`ifdef FETCH_BKPT_EN
  task automatic test_bkpt();
    int fetched;
    do_reset();
    lat = 1;
    BkptEn = 1'b1; BkptAddr = 16'h0110;
    BrLoad = 1'b1; BrTarget = 16'h010C;
    cyc();
    BrLoad = 1'b0;
    Run = 1'b1;
    fetched = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (E) begin
        checks++; if (InstrPC !== 16'h010C + 16'(2 * fetched)) begin failures++; $display("FAIL bk_seq act=%h req=%h", InstrPC, 16'h010C + 16'(2 * fetched)); end
        fetched++;
      end
    end
    checks++; if (fetched !== 2) begin failures++; $display("FAIL bk_count act=%0d req=2", fetched); end
    checks++; if (BkptHit !== 1'b1 || MemRd !== 1'b0 || PC !== 16'h0110) begin failures++; $display("FAIL bk_park act=%b/%b/%h req=1/0/0110", BkptHit, MemRd, PC); end
    BkptEn = 1'b0;
    cyc();
    checks++; if (BkptHit !== 1'b0 || MemRd !== 1'b1 || MemAddr !== 16'h0110) begin failures++; $display("FAIL bk_resume act=%b/%b/%h req=0/1/0110", BkptHit, MemRd, MemAddr); end
    cyc();
    checks++; if (E !== 1'b1 || InstrPC !== 16'h0110) begin failures++; $display("FAIL bk_fetch act=%b/%h req=1/0110", E, InstrPC); end
  endtask
`endif

  task automatic test_random();
    logic [15:0] exp_next, p_addr, p_tgt, p_instr;
    logic        p_rd, p_ack, p_br, p_stall;
    int          ne;
    do_reset();
    rand_lat = 1'b1;
    junk = 1'b1;
    lat = 1;
    exp_next = 16'h0100;
    ne = 0;
    for (int n = 0; n < 800; n++) begin
      Run = ($urandom % 8) != 0;
      Stall = ($urandom % 3) == 0;
      BrLoad = ($urandom % 16) == 0;
      BrTarget = ($urandom % 4 == 0) ? 16'hFFFC : {15'($urandom), 1'b0};
      p_rd = MemRd; p_ack = MemAck; p_addr = MemAddr;
      p_br = BrLoad; p_tgt = BrTarget; p_stall = Stall; p_instr = Instr;
      cyc();
      checks++; if (FLT !== 1'b0) begin failures++; $display("FAIL rnd_flt n=%0d act=%b req=0", n, FLT); end
      if (p_br) begin
        checks++; if (E !== 1'b0 || MemRd !== 1'b0 || PC !== p_tgt) begin failures++; $display("FAIL rnd_br n=%0d act=%b/%b/%h req=0/0/%h", n, E, MemRd, PC, p_tgt); end
        exp_next = p_tgt;
      end else begin
        if (E) begin
          ne++;
          checks++; if (p_stall !== 1'b0) begin failures++; $display("FAIL rnd_stall_e n=%0d act=1 req=0", n); end
          checks++; if (InstrPC !== exp_next || Instr !== memword(exp_next)) begin failures++; $display("FAIL rnd_order n=%0d act=%h/%h req=%h/%h", n, InstrPC, Instr, exp_next, memword(exp_next)); end
          exp_next = exp_next + 16'd2;
        end
        if (p_rd && p_ack) begin
          checks++; if (PC !== p_addr + 16'd2 || Instr !== memword(p_addr)) begin failures++; $display("FAIL rnd_cap n=%0d act=%h/%h req=%h/%h", n, PC, Instr, p_addr + 16'd2, memword(p_addr)); end
        end
        if (p_rd && !p_ack) begin
          checks++; if (MemRd !== 1'b1 || MemAddr !== p_addr) begin failures++; $display("FAIL rnd_stable n=%0d act=%b/%h req=1/%h", n, MemRd, MemAddr, p_addr); end
        end
      end
      if (!(p_rd && p_ack && !p_br)) begin
        checks++; if (Instr !== p_instr) begin failures++; $display("FAIL rnd_instr n=%0d act=%h req=%h", n, Instr, p_instr); end
      end
    end
    checks++; if (ne < 50) begin failures++; $display("FAIL rnd_progress act=%0d req>=50", ne); end
    rand_lat = 1'b0;
    junk = 1'b0;
    lat = 1;
  endtask

  initial begin
    Reset_n = 1'b0;
    drive_idle();
    test_reset();
    test_first_fetch();
    test_stall();
    test_branch_on_ack();
    test_latency();
    test_wrap();
    test_run_stop();
    test_async_reset();
    test_fault();
`ifdef FETCH_BKPT_EN
    test_bkpt();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
